// File: rtl/uart_mem_pkg.sv
// Shared types and constants for the UART subsystem's on-chip RAM arbiter.
// The UART_MEM_ARB_RR_EN macro selects round-robin (defined) or fixed priority (undefined).
package uart_mem_pkg;

  localparam int UART_MEM_ADDR_W      = 12;
  localparam int UART_MEM_DATA_W      = 32;
  localparam int UART_MEM_QUANTUM_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY0 = 2'd1,
    ARB_BUSY1 = 2'd2
  } arb_state_t;

  // Owner state corresponding to a grant index (0 -> m0, 1 -> m1).
  function automatic arb_state_t busy_of(input logic sel);
    return sel ? ARB_BUSY1 : ARB_BUSY0;
  endfunction

endpackage

// File: rtl/uart_mem_arb_grant.sv
// Combinational grant decision for the two-port RAM arbiter.
// UART_MEM_ARB_RR_EN defined: round-robin with quantum; undefined: m0 fixed priority.
module uart_mem_arb_grant
  import uart_mem_pkg::*;
#(
  parameter int QUANTUM = UART_MEM_QUANTUM_DEF,
  parameter int CNT_W   = $clog2(QUANTUM + 1)
) (
  input  logic [1:0]       req,
  input  arb_state_t       state,
  input  logic [CNT_W-1:0] cnt,
  input  logic             reset_req,
  output logic [1:0]       grant
);

  logic [1:0] tie_grant;

`ifdef UART_MEM_ARB_RR_EN
  localparam logic [CNT_W-1:0] Q_CNT = CNT_W'(QUANTUM);

  // The owner keeps the RAM until it has used its quantum, then hands over.
  always_comb begin
    tie_grant = 2'b01;
    case (state)
      ARB_BUSY0: tie_grant = (cnt < Q_CNT) ? 2'b01 : 2'b10;
      ARB_BUSY1: tie_grant = (cnt < Q_CNT) ? 2'b10 : 2'b01;
      default:   tie_grant = 2'b01;
    endcase
  end
`else
  logic unused_arb;

  assign tie_grant  = 2'b01;
  assign unused_arb = ^{state, cnt};
`endif

  always_comb begin
    grant = 2'b00;
    if (!reset_req) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = tie_grant;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Two-requester arbiter for the UART subsystem's single-port RAM (m0 = CPU, m1 = UART buffers).
// UART_MEM_ARB_RR_EN defined selects round-robin with quantum; otherwise m0 has fixed priority.
module uart_mem_arbiter
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W  = UART_MEM_ADDR_W,
  parameter int DATA_W  = UART_MEM_DATA_W,
  parameter int QUANTUM = UART_MEM_QUANTUM_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int CNT_W = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0] Q_CNT = CNT_W'(QUANTUM);

  arb_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rd_pend_reg, rd_pend_next;
  logic             rd_id_reg, rd_id_next;

  logic [1:0] req;
  logic [1:0] grant_raw;
  logic [1:0] grant;
  logic       gsel;
  logic       sel_read;
  logic       sel_write;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  uart_mem_arb_grant #(
    .QUANTUM (QUANTUM),
    .CNT_W   (CNT_W)
  ) u_grant (
    .req       (req),
    .state     (state_reg),
    .cnt       (cnt_reg),
    .reset_req (reset_req),
    .grant     (grant_raw)
  );

  // Nothing is accepted while the block itself is in reset.
  assign grant     = grant_raw & {2{~reset}};
  assign gsel      = grant[1];
  assign sel_read  = gsel ? m1_read  : m0_read;
  assign sel_write = gsel ? m1_write : m0_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ARB_IDLE;
      cnt_reg     <= '0;
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rd_pend_reg <= rd_pend_next;
      rd_id_reg   <= rd_id_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    rd_pend_next = 1'b0;
    rd_id_next   = rd_id_reg;
    if (!reset_req) begin
      if (grant != 2'b00) begin
        if (state_reg == busy_of(gsel)) begin
          cnt_next = (cnt_reg == Q_CNT) ? cnt_reg : cnt_reg + CNT_W'(1);
        end else begin
          state_next = busy_of(gsel);
          cnt_next   = CNT_W'(1);
        end
        // A simultaneous read and write is treated as a write only.
        rd_pend_next = sel_read & ~sel_write;
        rd_id_next   = gsel;
      end else if (req == 2'b00) begin
        state_next = ARB_IDLE;
        cnt_next   = '0;
      end
    end
  end

  assign m0_waitrequest   = ~grant[0];
  assign m1_waitrequest   = ~grant[1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend_reg & ~rd_id_reg & ~reset;
  assign m1_readdatavalid = rd_pend_reg &  rd_id_reg & ~reset;

  assign ram_chipselect = |grant;
  assign ram_write      = (|grant) & sel_write;
  assign ram_address    = gsel ? m1_address    : m0_address;
  assign ram_byteenable = gsel ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = gsel ? m1_writedata  : m0_writedata;
  assign ram_clken      = ~reset_req;

endmodule
